// File: rtl/mux_seq.sv
// Channel multiplexer that streams either one selected channel or a full scan
// of all channels from a snapshot taken when the request is accepted.
module mux_seq #(
    parameter int unsigned N  = 32,
    parameter int unsigned CH = 8,
    localparam int unsigned SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            start,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [CH*N-1:0] din,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [N-1:0]    out_data,
    output logic [SW-1:0]   out_idx,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CH*N-1:0] snap_q, snap_d;
    logic            valid_d, busy_d, done_d;
    logic [N-1:0]    data_d;
    logic [SW-1:0]   idx_d;
    logic [SW-1:0]   idx_nx_c;
    logic            hs_c;

    assign hs_c     = out_valid & out_ready;
    assign idx_nx_c = out_idx + SW'(1);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            out_valid <= valid_d;
            out_data  <= data_d;
            out_idx   <= idx_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next-state and next-output logic; clear overrides start and handshakes
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        valid_d = out_valid;
        data_d  = out_data;
        idx_d   = out_idx;
        done_d  = 1'b0;

        if (clear) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_d  = din;
                        valid_d = 1'b1;
                        if (mode) begin
                            state_d = SCAN;
                            data_d  = din[N-1:0];
                            idx_d   = '0;
                        end else begin
                            state_d = DIRECT;
                            data_d  = din[N*32'(sel) +: N];
                            idx_d   = sel;
                        end
                    end
                end
                DIRECT: begin
                    if (hs_c) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                SCAN: begin
                    if (hs_c) begin
                        if (out_idx == SW'(CH - 1)) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d  = idx_nx_c;
                            data_d = snap_q[N*32'(idx_nx_c) +: N];
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_mux_seq.sv
// Randomized and directed bench for mux_seq against a beat-queue reference model.
module tb_mux_seq;

    localparam int unsigned N  = 32;
    localparam int unsigned CH = 8;
    localparam int unsigned SW = $clog2(CH);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear, start, mode, out_ready;
    logic [SW-1:0]   sel;
    logic [CH*N-1:0] din;
    logic            out_valid, busy, done;
    logic [N-1:0]    out_data;
    logic [SW-1:0]   out_idx;

    mux_seq #(.N(N), .CH(CH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .start    (start),
        .mode     (mode),
        .sel      (sel),
        .din      (din),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_idx  (out_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] idx;
        logic [N-1:0]  data;
    } beat_t;

    // Reference: pending beats of the current transfer, plus what is on the bus
    beat_t         q[$];
    logic          m_done;
    logic [N-1:0]  sh_data;
    logic [SW-1:0] sh_idx;

    int total = 0;
    int bad   = 0;
    int vcount, dcount;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_done  = 1'b0;
        sh_data = '0;
        sh_idx  = '0;
    endtask

    // Check outputs mid-cycle, advance the model with the applied inputs, then cross one edge
    task automatic tick();
        beat_t b;
        @(negedge clk);
        check("valid", out_valid, q.size() != 0);
        check("busy",  busy,      q.size() != 0);
        check("done",  done,      m_done);
        check("data",  out_data,  sh_data);
        check("idx",   out_idx,   sh_idx);
        if (out_valid) vcount++;
        if (done) dcount++;

        if (!rst_n) begin
            model_reset();
        end else if (clear) begin
            q.delete();
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (q.size() == 0) begin
                if (start) begin
                    if (mode) begin
                        for (int k = 0; k < CH; k++) begin
                            b.idx  = SW'(k);
                            b.data = din[k*N +: N];
                            q.push_back(b);
                        end
                    end else begin
                        b.idx  = sel;
                        b.data = din[32'(sel)*N +: N];
                        q.push_back(b);
                    end
                end
            end else if (out_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) m_done = 1'b1;
            end
            if (q.size() != 0) begin
                sh_data = q[0].data;
                sh_idx  = q[0].idx;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_din();
        for (int k = 0; k < CH; k++) din[k*N +: N] = N'(32'h100 + k);
    endtask

    task automatic accept(input logic m, input logic [SW-1:0] s);
        start = 1'b1; mode = m; sel = s;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; start = 1'b0; mode = 1'b0;
        sel = '0; out_ready = 1'b1;
        set_default_din();
        model_reset();
        #2;
        check("reset_valid", out_valid, 1'b0);
        check("reset_data",  out_data,  '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Full scan with continuous ready
        vcount = 0; dcount = 0;
        accept(1'b1, '0);
        for (int i = 0; i < 8; i++) tick();
        check("scan_valid_cycles", vcount, 8);
        tick();
        check("scan_done_cycle9", dcount, 1);
        check("scan_last_data", out_data, 32'h107);
        tick();

        // Backpressure at index 2
        vcount = 0;
        accept(1'b1, '0);
        tick(); tick();
        out_ready = 1'b0;
        tick(); tick(); tick();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("bp_valid_cycles", vcount, 11);

        // Direct mode
        vcount = 0; dcount = 0;
        accept(1'b0, SW'(5));
        check("direct_data", out_data, 32'h105);
        check("direct_idx",  out_idx,  5);
        tick(); tick();
        check("direct_counts", {vcount, dcount}, {32'd1, 32'd1});

        // Snapshot isolation and start while busy
        accept(1'b1, '0);
        tick();
        din = '1;
        start = 1'b1; tick(); tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("snap_idle", busy, 1'b0);
        set_default_din();

        // Clear at index 4
        dcount = 0;
        accept(1'b1, '0);
        for (int i = 0; i < 4; i++) tick();
        check("clr_at_idx4", out_idx, 4);
        clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
        tick(); tick();
        check("clr_no_done", dcount, 0);
        check("clr_held", out_data, 32'h104);

        // Asynchronous reset at index 4
        dcount = 0;
        accept(1'b1, '0);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #2;
        check("arst_valid", out_valid, 1'b0);
        check("arst_busy",  busy,      1'b0);
        check("arst_done",  done,      1'b0);
        check("arst_data",  out_data,  '0);
        check("arst_idx",   out_idx,   '0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("arst_no_done", dcount, 0);
        accept(1'b0, SW'(3));
        check("arst_resume", out_data, 32'h103);
        tick(); tick();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            start     = ($urandom % 4) == 0;
            mode      = 1'($urandom);
            sel       = SW'($urandom);
            out_ready = ($urandom % 4) != 0;
            clear     = ($urandom % 60) == 0;
            for (int k = 0; k < CH; k++) din[k*N +: N] = N'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
